// File: rtl/wrapper_1500_bist_ctrl_pkg.sv
// Shared definitions for the 1500 wrapper BIST front end: instruction codes,
// run FSM states and bit offsets of the STATUS data register.
package wrapper_1500_pkg;

   localparam logic [2:0] WS_BYPASS = 3'b000;
   localparam logic [2:0] WS_RUN    = 3'b001;
   localparam logic [2:0] WS_STATUS = 3'b010;

   typedef enum logic [2:0] {
      IDLE,
      START,
      ARM,
      RUN,
      DONE
   } bist_state_e;

   // STATUS WDR layout, LSB shifted out first: {cnt, tmo, busy, done, pass}
   localparam int ST_PASS_BIT = 0;
   localparam int ST_DONE_BIT = 1;
   localparam int ST_BUSY_BIT = 2;
   localparam int ST_TMO_BIT  = 3;
   localparam int ST_CNT_LSB  = 4;

endpackage

// File: rtl/wrapper_1500_bist_ctrl_if.sv
// Serial wrapper access port (WSP subset): ATE/TAP side is master, the wrapper is slave.
interface wrapper_1500_bist_ctrl_if;
   logic selectwir;
   logic shiftwr;
   logic capturewr;
   logic updatewr;
   logic wsi;
   logic wso;

   modport master (output selectwir, shiftwr, capturewr, updatewr, wsi, input wso);
   modport slave  (input selectwir, shiftwr, capturewr, updatewr, wsi, output wso);
endinterface

// File: rtl/wrapper_1500_bist_ctrl_shift_reg.sv
// Capture/shift register stage used for the WIR, WBY and STATUS registers.
// Capture wins over shift; shifting moves toward the LSB, which is the serial output.
module wrapper_shift_reg #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         capture,
   input  logic         shift,
   input  logic [W-1:0] cap_val,
   input  logic         si,
   output logic [W-1:0] q
);

   logic [W-1:0] shifted;

   generate
      if (W == 1) begin : g_one
         assign shifted = si;
      end else begin : g_multi
         assign shifted = {si, q[W-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (capture) begin
         q <= cap_val;
      end else if (shift) begin
         q <= shifted;
      end
   end

endmodule

// File: rtl/wrapper_1500_bist_ctrl.sv
// IEEE 1500-style wrapper front end for the SRAM MBIST engine: WIR decode, run FSM,
// status capture. Optional run timeout is enabled by defining WRAPPER_TIMEOUT_EN.
module wrapper_1500_bist_ctrl
   import wrapper_1500_pkg::*;
#(
   parameter int WIR_W = 3,
   parameter int CNT_W = 20
`ifdef WRAPPER_TIMEOUT_EN
   , parameter logic [CNT_W-1:0] TMO_CYC = 20'hFFFFF
`endif
) (
   input  logic                      clk,
   input  logic                      rst_n,
   wrapper_1500_bist_ctrl_if.slave   wif,
   output logic                      start_bist,
   input  logic                      bist_done,
   input  logic                      bist_pass,
   output logic                      bist_mode
);

   localparam int STAT_W = CNT_W + ST_CNT_LSB;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   bist_state_e       state, state_nxt;
   logic [WIR_W-1:0]  wir_q, wir_active;
   logic              wby_q;
   logic [STAT_W-1:0] stat_q, status_live;
   logic [CNT_W-1:0]  cnt;
   logic              done, pass, tmo, busy;
   logic              do_upd, do_cap, do_shift;
   logic              sel_status, run_req, run_start, tmo_hit;
   logic              sel_lsb, wso_p0;

   // updatewr masks capturewr, which masks shiftwr
   assign do_upd     = wif.updatewr;
   assign do_cap     = wif.capturewr & ~wif.updatewr;
   assign do_shift   = wif.shiftwr & ~wif.capturewr & ~wif.updatewr;
   assign sel_status = (wir_active == WIR_W'(WS_STATUS));
   assign run_req    = do_upd & ~wif.selectwir & (wir_active == WIR_W'(WS_RUN));
   assign run_start  = run_req & ((state == IDLE) | (state == DONE));

   wrapper_shift_reg #(.W(WIR_W)) u_wir (
      .clk(clk), .rst_n(rst_n),
      .capture(do_cap & wif.selectwir), .shift(do_shift & wif.selectwir),
      .cap_val(wir_active), .si(wif.wsi), .q(wir_q)
   );

   wrapper_shift_reg #(.W(1)) u_wby (
      .clk(clk), .rst_n(rst_n),
      .capture(do_cap & ~wif.selectwir & ~sel_status),
      .shift(do_shift & ~wif.selectwir & ~sel_status),
      .cap_val(1'b0), .si(wif.wsi), .q(wby_q)
   );

   wrapper_shift_reg #(.W(STAT_W)) u_status (
      .clk(clk), .rst_n(rst_n),
      .capture(do_cap & ~wif.selectwir & sel_status),
      .shift(do_shift & ~wif.selectwir & sel_status),
      .cap_val(status_live), .si(wif.wsi), .q(stat_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wir_active <= WIR_W'(WS_BYPASS);
      end else if (do_upd & wif.selectwir) begin
         wir_active <= wir_q;
      end
   end

   always_comb begin
      if (wif.selectwir) begin
         sel_lsb = wir_q[0];
      end else if (sel_status) begin
         sel_lsb = stat_q[0];
      end else begin
         sel_lsb = wby_q;
      end
   end

   // ---- stage p0: registered serial output ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wso_p0 <= 1'b0;
      end else begin
         wso_p0 <= sel_lsb;
      end
   end
   assign wif.wso = wso_p0;

`ifdef WRAPPER_TIMEOUT_EN
   assign tmo_hit = (state == RUN) & ~bist_done & (cnt == TMO_CYC);
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (run_req) state_nxt = START;
         START:   state_nxt = ARM;
         ARM:     state_nxt = RUN;   // engine may still present the previous run's done
         RUN:     if (bist_done || tmo_hit) state_nxt = DONE;
         DONE:    state_nxt = run_req ? START : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      start_bist = (state == START);
      busy       = (state == START) | (state == ARM) | (state == RUN);
      bist_mode  = busy;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         done <= 1'b0;
         pass <= 1'b0;
         tmo  <= 1'b0;
      end else if (run_start) begin
         cnt  <= '0;
         done <= 1'b0;
         pass <= 1'b0;
         tmo  <= 1'b0;
      end else if (state == RUN) begin
         cnt <= sat_inc(cnt);
         if (bist_done) begin
            done <= 1'b1;
            pass <= bist_pass;
         end else if (tmo_hit) begin
            done <= 1'b1;
            pass <= 1'b0;
            tmo  <= 1'b1;
         end
      end
   end

   always_comb begin
      status_live = '0;
      status_live[ST_PASS_BIT] = pass;
      status_live[ST_DONE_BIT] = done;
      status_live[ST_BUSY_BIT] = busy;
      status_live[ST_TMO_BIT]  = tmo;
      status_live[STAT_W-1:ST_CNT_LSB] = cnt;
   end

endmodule

// File: tb/tb_wrapper_1500_bist_ctrl.sv
// Directed + randomized bench for wrapper_1500_bist_ctrl with a behavioural model
// of the engine handshake and the STATUS register contents.
module tb_wrapper_1500_bist_ctrl;

   localparam int CNT_W  = 20;
   localparam int STAT_W = CNT_W + 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start_bist, bist_mode;
   logic bist_done = 1'b0;
   logic bist_pass = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int starts = 0;
   int req_cyc = 0;

   wrapper_1500_bist_ctrl_if wif ();

   wrapper_1500_bist_ctrl #(
      .WIR_W(3),
      .CNT_W(CNT_W)
`ifdef WRAPPER_TIMEOUT_EN
      , .TMO_CYC(20'd100)
`endif
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .wif(wif),
      .start_bist(start_bist),
      .bist_done(bist_done),
      .bist_pass(bist_pass),
      .bist_mode(bist_mode)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (start_bist === 1'b1) starts = starts + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Status register as seen by ATE: {cnt, tmo, busy, done, pass}
   function automatic logic [STAT_W-1:0] exp_status(input int c, input bit t, input bit b,
                                                     input bit d, input bit p);
      logic [CNT_W-1:0] cv;
      cv = CNT_W'(c);
      return {cv, t, b, d, p};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_wir(input logic [2:0] code);
      wif.selectwir = 1'b1;
      wif.shiftwr   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wif.wsi = code[i];
         tick();
      end
      wif.shiftwr  = 1'b0;
      wif.updatewr = 1'b1;
      tick();
      wif.updatewr  = 1'b0;
      wif.selectwir = 1'b0;
      wif.wsi       = 1'b0;
   endtask

   task automatic read_status(output logic [STAT_W-1:0] v, output int cap_cyc);
      v = '0;
      wif.selectwir = 1'b0;
      wif.capturewr = 1'b1;
      tick();
      cap_cyc = cyc;
      wif.capturewr = 1'b0;
      wif.shiftwr   = 1'b1;
      for (int i = 0; i < STAT_W; i++) begin
         tick();
         v[i] = wif.wso;
      end
      wif.shiftwr = 1'b0;
   endtask

   task automatic request();
      wif.selectwir = 1'b0;
      wif.updatewr  = 1'b1;
      tick();
      wif.updatewr = 1'b0;
      req_cyc = cyc;
   endtask

   // Engine raises done so that the run FSM sees it lat edges after the request.
   // The run spends one cycle in START and one in ARM, then every RUN edge
   // (including the one that sees done) adds one to cnt: cnt = lat - 2.
   task automatic do_run(input int lat, input logic pv, input bit stale, input bit dbl,
                         input string tag);
      int s0;
      int cc;
      logic [STAT_W-1:0] got;
      load_wir(3'b001);
      s0 = starts;
      if (stale) bist_done = 1'b1;
      request();
      check({tag, "_start_hi"}, start_bist, 1'b1);
      check({tag, "_mode_hi"}, bist_mode, 1'b1);
      for (int k = 1; k < lat; k++) begin
         if (dbl && k == 5) wif.updatewr = 1'b1;
         tick();
         wif.updatewr = 1'b0;
         if (k == 1) check({tag, "_start_1cyc"}, start_bist, 1'b0);
         if (stale && k == 2) bist_done = 1'b0;
         if (stale && k == 3) check({tag, "_stale_ignored"}, bist_mode, 1'b1);
      end
      check({tag, "_mode_before_done"}, bist_mode, 1'b1);
      bist_done = 1'b1;
      bist_pass = pv;
      tick();
      check({tag, "_mode_after_done"}, bist_mode, 1'b0);
      bist_done = 1'b0;
      bist_pass = 1'b0;
      tick();
      check({tag, "_one_start"}, 64'(starts - s0), 64'd1);
      load_wir(3'b010);
      read_status(got, cc);
      check({tag, "_status"}, got, exp_status(lat - 2, 1'b0, 1'b0, 1'b1, pv));
   endtask

   initial begin
      logic [STAT_W-1:0] got;
      int cc;
      logic prev;
      logic b;

      wif.selectwir = 1'b0;
      wif.shiftwr   = 1'b0;
      wif.capturewr = 1'b0;
      wif.updatewr  = 1'b0;
      wif.wsi       = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_wso", wif.wso, 1'b0);
      check("rst_start", start_bist, 1'b0);
      check("rst_mode", bist_mode, 1'b0);
      rst_n = 1'b1;
      tick();

      // BYPASS after reset: 1-bit WBY, wso delayed one shift
      wif.shiftwr = 1'b1;
      wif.wsi = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("byp_ones", wif.wso, (i == 0) ? 1'b0 : 1'b1);
      end
      prev = 1'b1;
      for (int i = 0; i < 12; i++) begin
         b = 1'($urandom_range(0, 1));
         wif.wsi = b;
         tick();
         check("byp_rand", wif.wso, prev);
         prev = b;
      end
      wif.shiftwr = 1'b0;
      check("byp_no_start", 64'(starts), 64'd0);

      // Status right after reset is all zero
      load_wir(3'b010);
      read_status(got, cc);
      check("status_reset", got, exp_status(0, 1'b0, 1'b0, 1'b0, 1'b0));

      do_run(2048, 1'b1, 1'b0, 1'b0, "run2048_pass");
      do_run(64, 1'b0, 1'b0, 1'b0, "run_fail");
      do_run(40, 1'b1, 1'b1, 1'b0, "stale_done");
      do_run(90, 1'b1, 1'b0, 1'b1, "busy_rereq");
      for (int r = 0; r < 3; r++) begin
         do_run(int'($urandom_range(8, 250)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_run");
      end

      // Reset during START drops start_bist asynchronously
      load_wir(3'b001);
      request();
      check("rst_start_pre", start_bist, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_start_async", start_bist, 1'b0);
      check("rst_mode_async0", bist_mode, 1'b0);
      #1;
      rst_n = 1'b1;
      tick();

      // Reset mid-RUN, then status must read all zero
      load_wir(3'b001);
      request();
      repeat (50) tick();
      check("midrun_mode_pre", bist_mode, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrun_mode_async", bist_mode, 1'b0);
      check("midrun_start_async", start_bist, 1'b0);
      #1;
      rst_n = 1'b1;
      tick();
      load_wir(3'b010);
      read_status(got, cc);
      check("status_after_rst", got, exp_status(0, 1'b0, 1'b0, 1'b0, 1'b0));

      // Engine never reports done
      load_wir(3'b001);
      request();
      repeat (150) tick();
      load_wir(3'b010);
      read_status(got, cc);
`ifdef WRAPPER_TIMEOUT_EN
      check("tmo_flags", got[3:0], 4'b1010);
      check("tmo_mode", bist_mode, 1'b0);
`else
      // Capture edge sees the cnt left by the previous edge: (cc - req_cyc - 1) - 2
      check("no_tmo_live", got, exp_status(cc - req_cyc - 3, 1'b0, 1'b1, 1'b0, 1'b0));
      check("no_tmo_mode", bist_mode, 1'b1);
`endif
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("final_idle_mode", bist_mode, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
